// File: rtl/alu_srca_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_srca_pkg
// Brief    : Shared types and constants for the ALU source-A issue block.
// Revision : 1.0 - initial release
// ============================================================================
package alu_srca_pkg;

    localparam int SRCA_WIDTH = 8;

    typedef enum logic [1:0] {
        SRCA_ONE       = 2'b00,
        SRCA_MINUS_ONE = 2'b01,
        SRCA_PASS      = 2'b10,
        SRCA_NEG       = 2'b11
    } srca_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PREP  = 2'b01,
        ISSUE = 2'b10,
        DONE  = 2'b11
    } srca_state_t;

endpackage
`default_nettype wire

// File: rtl/srca_negate.sv
`default_nettype none
// ============================================================================
// Module   : srca_negate
// Brief    : Registered two's-complement negation with load enable.
// Revision : 1.0 - initial release
// ============================================================================
module srca_negate #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_neg
);

    logic [WIDTH-1:0] r_neg;

    // Truncation is intentional: the most negative value negates to itself.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_neg <= '0;
        end else if (i_load) begin
            r_neg <= ~i_data + WIDTH'(1);
        end
    end

    assign o_neg = r_neg;

endmodule
`default_nettype wire

// File: rtl/alu_srca_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_srca_issue
// Brief    : Issues a latched source-A select/operand to the ALU for a
//            programmed number of handshaked beats.
//            Optional macro SRCA_ISSUE_BYPASS_EN skips PREP for ops 00/01/10.
// Revision : 1.0 - initial release
// ============================================================================
module alu_srca_issue
    import alu_srca_pkg::*;
#(
    parameter int WIDTH = SRCA_WIDTH,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [WIDTH-1:0] req_data,
    input  logic [CNT_W-1:0] req_count,
    output logic [1:0]       Sel_SrcA,
    output logic [WIDTH-1:0] inputA,
    output logic [WIDTH-1:0] neg_inputA,
    output logic             issue_valid,
    input  logic             issue_ready,
    output logic             done
);

    srca_state_t      r_state;
    srca_sel_t        r_sel;
    logic [WIDTH-1:0] r_inputA;
    logic [CNT_W-1:0] r_remaining;
    logic             r_issueValid;
    logic             r_done;
    logic             r_reqReady;

    logic             w_accept;
    logic             w_skipPrep;
    logic             w_negLoad;
    logic [WIDTH-1:0] w_negIn;

    assign w_accept = (r_state == IDLE) && req_valid;

`ifdef SRCA_ISSUE_BYPASS_EN
    assign w_skipPrep = (srca_sel_t'(req_op) != SRCA_NEG);
`else
    assign w_skipPrep = 1'b0;
`endif

    // Bypassed ops negate straight from the request so the value is ready
    // on the first issued beat; otherwise PREP negates the latched operand.
    assign w_negLoad = (w_accept && w_skipPrep) || (r_state == PREP);
    assign w_negIn   = (r_state == IDLE) ? req_data : r_inputA;

    srca_negate #(
        .WIDTH (WIDTH)
    ) u_negate (
        .clk    (CLK),
        .rst    (reset),
        .i_load (w_negLoad),
        .i_data (w_negIn),
        .o_neg  (neg_inputA)
    );

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_sel        <= SRCA_ONE;
            r_inputA     <= '0;
            r_remaining  <= '0;
            r_issueValid <= 1'b0;
            r_done       <= 1'b0;
            r_reqReady   <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_sel       <= srca_sel_t'(req_op);
                        r_inputA    <= req_data;
                        r_remaining <= req_count;
                        r_reqReady  <= 1'b0;
                        if (req_count == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else if (w_skipPrep) begin
                            r_state      <= ISSUE;
                            r_issueValid <= 1'b1;
                        end else begin
                            r_state <= PREP;
                        end
                    end
                end
                PREP: begin
                    r_state      <= ISSUE;
                    r_issueValid <= 1'b1;
                end
                ISSUE: begin
                    if (issue_ready && (r_remaining != '0)) begin
                        r_remaining <= r_remaining - CNT_W'(1);
                        if (r_remaining == CNT_W'(1)) begin
                            r_state      <= DONE;
                            r_issueValid <= 1'b0;
                            r_done       <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state    <= IDLE;
                    r_reqReady <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign req_ready   = r_reqReady;
    assign Sel_SrcA    = r_sel;
    assign inputA      = r_inputA;
    assign issue_valid = r_issueValid;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_alu_srca_issue.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_srca_issue
// Brief    : Directed self-checking bench for alu_srca_issue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_srca_issue;

`ifdef SRCA_ISSUE_BYPASS_EN
    localparam bit c_BYP = 1'b1;
`else
    localparam bit c_BYP = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [1:0] req_op;
    logic [7:0] req_data;
    logic [3:0] req_count;
    logic [1:0] Sel_SrcA;
    logic [7:0] inputA;
    logic [7:0] neg_inputA;
    logic       issue_valid;
    logic       issue_ready;
    logic       done;

    int tests = 0;
    int fails = 0;

    alu_srca_issue #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK         (CLK),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_data    (req_data),
        .req_count   (req_count),
        .Sel_SrcA    (Sel_SrcA),
        .inputA      (inputA),
        .neg_inputA  (neg_inputA),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .done        (done)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic start(input logic [1:0] op, input logic [7:0] data, input logic [3:0] cnt);
        req_valid = 1'b1; req_op = op; req_data = data; req_count = cnt;
        tick();
        req_valid = 1'b0;
    endtask

    // Checks the PREP cycle (no beat yet) where one is expected, then advances.
    task automatic pass_prep(input logic [1:0] op);
        if (op == 2'b11 || !c_BYP) begin
            tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL prep_valid got %0h exp 0", issue_valid); end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 1'b0; req_op = 2'b00; req_data = 8'h00; req_count = 4'h0; issue_ready = 1'b0;
        tick(); tick();
        tests++; if ({Sel_SrcA, inputA, neg_inputA, issue_valid, done} !== 20'h0) begin fails++; $display("FAIL reset_outs got %h exp 0", {Sel_SrcA, inputA, neg_inputA, issue_valid, done}); end
        reset = 1'b0;
        tick();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready got %0h exp 1", req_ready); end
    endtask

    task automatic test_single();
        issue_ready = 1'b1;
        start(2'b10, 8'h05, 4'd1);
        tests++; if (req_ready !== 1'b0) begin fails++; $display("FAIL single_busy got %0h exp 0", req_ready); end
        pass_prep(2'b10);
        tests++; if ({issue_valid, Sel_SrcA, inputA, neg_inputA} !== {1'b1, 2'b10, 8'h05, 8'hFB}) begin fails++; $display("FAIL single_beat got %h exp %h", {issue_valid, Sel_SrcA, inputA, neg_inputA}, {1'b1, 2'b10, 8'h05, 8'hFB}); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL single_early_done got %0h exp 0", done); end
        tick();
        tests++; if ({done, issue_valid} !== 2'b10) begin fails++; $display("FAIL single_done got %b exp 10", {done, issue_valid}); end
        tick();
        tests++; if ({done, req_ready, inputA, neg_inputA} !== {1'b0, 1'b1, 8'h05, 8'hFB}) begin fails++; $display("FAIL single_idle got %h exp %h", {done, req_ready, inputA, neg_inputA}, {1'b0, 1'b1, 8'h05, 8'hFB}); end
    endtask

    task automatic test_backpressure();
        logic [4:0] pat;
        int hs;
        pat = 5'b10101;
        hs = 0;
        issue_ready = 1'b0;
        start(2'b11, 8'h80, 4'd3);
        pass_prep(2'b11);
        for (int k = 0; k < 5; k++) begin
            tests++; if ({issue_valid, done, Sel_SrcA, neg_inputA} !== {1'b1, 1'b0, 2'b11, 8'h80}) begin fails++; $display("FAIL bp_beat%0d got %h exp %h", k, {issue_valid, done, Sel_SrcA, neg_inputA}, {1'b1, 1'b0, 2'b11, 8'h80}); end
            issue_ready = pat[k];
            if (issue_valid && pat[k]) hs++;
            tick();
        end
        issue_ready = 1'b0;
        tests++; if (hs !== 3) begin fails++; $display("FAIL bp_handshakes got %0d exp 3", hs); end
        tests++; if ({done, issue_valid, neg_inputA} !== {1'b1, 1'b0, 8'h80}) begin fails++; $display("FAIL bp_done got %h exp %h", {done, issue_valid, neg_inputA}, {1'b1, 1'b0, 8'h80}); end
        tick();
        tests++; if (req_ready !== 1'b1) begin fails++; $display("FAIL bp_ready got %0h exp 1", req_ready); end
    endtask

    task automatic test_back_to_back();
        issue_ready = 1'b1;
        start(2'b01, 8'h07, 4'd4);
        pass_prep(2'b01);
        for (int k = 0; k < 4; k++) begin
            tests++; if ({issue_valid, done, Sel_SrcA, neg_inputA} !== {1'b1, 1'b0, 2'b01, 8'hF9}) begin fails++; $display("FAIL b2b_beat%0d got %h exp %h", k, {issue_valid, done, Sel_SrcA, neg_inputA}, {1'b1, 1'b0, 2'b01, 8'hF9}); end
            tick();
        end
        tests++; if ({done, issue_valid} !== 2'b10) begin fails++; $display("FAIL b2b_done got %b exp 10", {done, issue_valid}); end
        tick();
    endtask

    task automatic test_zero_count();
        issue_ready = 1'b1;
        start(2'b10, 8'h11, 4'd0);
        tests++; if ({done, issue_valid, req_ready, inputA} !== {1'b1, 1'b0, 1'b0, 8'h11}) begin fails++; $display("FAIL zero_done got %h exp %h", {done, issue_valid, req_ready, inputA}, {1'b1, 1'b0, 1'b0, 8'h11}); end
        tick();
        tests++; if ({done, issue_valid, req_ready} !== 3'b001) begin fails++; $display("FAIL zero_ready got %b exp 001", {done, issue_valid, req_ready}); end
    endtask

    task automatic test_busy();
        issue_ready = 1'b0;
        start(2'b10, 8'h21, 4'd2);
        pass_prep(2'b10);
        req_valid = 1'b1; req_op = 2'b01; req_data = 8'h33; req_count = 4'd5;
        for (int k = 0; k < 3; k++) begin
            tests++; if ({issue_valid, req_ready, Sel_SrcA, inputA} !== {1'b1, 1'b0, 2'b10, 8'h21}) begin fails++; $display("FAIL busy_hold%0d got %h exp %h", k, {issue_valid, req_ready, Sel_SrcA, inputA}, {1'b1, 1'b0, 2'b10, 8'h21}); end
            tick();
        end
        issue_ready = 1'b1;
        tick();
        tests++; if ({issue_valid, inputA} !== {1'b1, 8'h21}) begin fails++; $display("FAIL busy_beat got %h exp %h", {issue_valid, inputA}, {1'b1, 8'h21}); end
        tick();
        tests++; if ({done, inputA} !== {1'b1, 8'h21}) begin fails++; $display("FAIL busy_done got %h exp %h", {done, inputA}, {1'b1, 8'h21}); end
        req_valid = 1'b0; issue_ready = 1'b0;
        tick();
        tests++; if ({req_ready, Sel_SrcA, inputA} !== {1'b1, 2'b10, 8'h21}) begin fails++; $display("FAIL busy_after got %h exp %h", {req_ready, Sel_SrcA, inputA}, {1'b1, 2'b10, 8'h21}); end
    endtask

    task automatic test_reset_mid();
        issue_ready = 1'b0;
        start(2'b10, 8'h44, 4'd3);
        pass_prep(2'b10);
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL mid_pre got %0h exp 1", issue_valid); end
        #2 reset = 1'b1;
        #1;
        tests++; if ({Sel_SrcA, inputA, neg_inputA, issue_valid, done, req_ready} !== 21'h1) begin fails++; $display("FAIL mid_async got %h exp 1", {Sel_SrcA, inputA, neg_inputA, issue_valid, done, req_ready}); end
        tick();
        reset = 1'b0;
        tick();
        tests++; if ({req_ready, issue_valid, done} !== 3'b100) begin fails++; $display("FAIL mid_release got %b exp 100", {req_ready, issue_valid, done}); end
        issue_ready = 1'b1;
        start(2'b00, 8'h00, 4'd1);
        pass_prep(2'b00);
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL mid_new_beat got %0h exp 1", issue_valid); end
        tick();
        tests++; if ({done, issue_valid} !== 2'b10) begin fails++; $display("FAIL mid_new_done got %b exp 10", {done, issue_valid}); end
        tick();
    endtask

`ifdef SRCA_ISSUE_BYPASS_EN
    task automatic test_bypass();
        issue_ready = 1'b1;
        start(2'b00, 8'h09, 4'd2);
        tests++; if ({issue_valid, Sel_SrcA, neg_inputA} !== {1'b1, 2'b00, 8'hF7}) begin fails++; $display("FAIL byp_first got %h exp %h", {issue_valid, Sel_SrcA, neg_inputA}, {1'b1, 2'b00, 8'hF7}); end
        tick();
        tests++; if (issue_valid !== 1'b1) begin fails++; $display("FAIL byp_second got %0h exp 1", issue_valid); end
        tick();
        tests++; if (done !== 1'b1) begin fails++; $display("FAIL byp_done got %0h exp 1", done); end
        tick();
        start(2'b11, 8'h02, 4'd1);
        tests++; if (issue_valid !== 1'b0) begin fails++; $display("FAIL byp_neg_prep got %0h exp 0", issue_valid); end
        tick();
        tests++; if ({issue_valid, neg_inputA} !== {1'b1, 8'hFE}) begin fails++; $display("FAIL byp_neg_beat got %h exp %h", {issue_valid, neg_inputA}, {1'b1, 8'hFE}); end
        tick(); tick();
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_zero_count();
        test_busy();
        test_reset_mid();
`ifdef SRCA_ISSUE_BYPASS_EN
        test_bypass();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
